// File: rtl/cpu_shift_pkg.sv
// Shared encodings for the shift/rotate unit: op codes, FSM states and op-class helpers.
package cpu_shift_pkg;

    typedef enum logic [2:0] {
        SH_SLL = 3'b000,
        SH_SRL = 3'b001,
        SH_SRA = 3'b010,
        SH_ROL = 3'b011,
        SH_ROR = 3'b100
    } sh_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } sh_state_e;

    function automatic logic is_rot(input logic [2:0] op);
        return (op == SH_ROL) || (op == SH_ROR);
    endfunction

    function automatic logic is_legal(input logic [2:0] op);
        return op <= SH_ROR;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step by i_s positions; SRA fills with i_sign, which the
// caller ties to the sign of the original operand so cascaded steps stay arithmetic.
module shift_step
    import cpu_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [2:0]       i_op,
    input  logic             i_sign,
    input  logic [SW-1:0]    i_s,
    output logic [WIDTH-1:0] o_data
);

    logic [SW:0]      w_inv;
    logic [WIDTH-1:0] w_fill;

    // Shifting by WIDTH yields zero, so a zero step leaves rotates unchanged.
    assign w_inv  = (SW+1)'(WIDTH) - {1'b0, i_s};
    assign w_fill = i_sign ? ~({WIDTH{1'b1}} >> i_s) : '0;

    always_comb begin
        o_data = '0;
        case (i_op)
            SH_SLL:  o_data = i_data << i_s;
            SH_SRL:  o_data = i_data >> i_s;
            SH_SRA:  o_data = (i_data >> i_s) | w_fill;
            SH_ROL:  o_data = (i_data << i_s) | (i_data >> w_inv);
            SH_ROR:  o_data = (i_data >> i_s) | (i_data << w_inv);
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate operand producer with valid/ready on both sides.
// Define SHIFT_UNIT_FAST_EN to replace the iterative RUN phase with a single-cycle barrel shifter.
module shift_unit
    import cpu_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_shift,
    output logic [WIDTH-1:0]         out_rot,
    output logic                     out_zero,
    output logic                     out_err,
    output logic [1:0]               dbg_state
);

    localparam int SW = $clog2(WIDTH);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds valid and payload stable until that edge.
    sh_state_e        r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic             r_sign;
    logic [SW-1:0]    r_rem;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_rot;
    logic             r_zero;
    logic             r_err;

    logic [SW-1:0]    w_s;
    logic [SW-1:0]    w_rem_nxt;
    logic [WIDTH-1:0] w_step_out;
    logic [WIDTH-1:0] w_idle_data;
    logic             w_idle_done;
    logic             w_in_run;
    logic [2:0]       w_fin_op;
    logic [WIDTH-1:0] w_fin_data;
    logic             w_fin_err;
    logic             w_fin_rot;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_rot_nxt;
    logic             w_zero_nxt;

    assign w_s       = (r_rem > SW'(STEP)) ? SW'(STEP) : r_rem;
    assign w_rem_nxt = r_rem - w_s;

    shift_step #(.WIDTH(WIDTH), .SW(SW)) u_step (
        .i_data (r_data),
        .i_op   (r_op),
        .i_sign (r_sign),
        .i_s    (w_s),
        .o_data (w_step_out)
    );

`ifdef SHIFT_UNIT_FAST_EN
    logic [WIDTH-1:0] w_stage [SW+1];

    assign w_stage[0] = in_data;
    for (genvar k = 0; k < SW; k++) begin : g_barrel
        shift_step #(.WIDTH(WIDTH), .SW(SW)) u_stage (
            .i_data (w_stage[k]),
            .i_op   (in_op),
            .i_sign (in_data[WIDTH-1]),
            .i_s    (in_amt[k] ? SW'(1 << k) : '0),
            .o_data (w_stage[k+1])
        );
    end
    assign w_idle_data = w_stage[SW];
    assign w_idle_done = 1'b1;
`else
    assign w_idle_data = in_data;
    assign w_idle_done = (in_amt == '0) || !is_legal(in_op);
`endif

    // Result selection shared by the IDLE shortcut and the last RUN step.
    assign w_in_run    = (r_state == ST_RUN);
    assign w_fin_op    = w_in_run ? r_op : in_op;
    assign w_fin_data  = w_in_run ? w_step_out : w_idle_data;
    assign w_fin_err   = w_in_run ? 1'b0 : !is_legal(in_op);
    assign w_fin_rot   = is_rot(w_fin_op);
    assign w_shift_nxt = (w_fin_err || w_fin_rot) ? '0 : w_fin_data;
    assign w_rot_nxt   = (!w_fin_err && w_fin_rot) ? w_fin_data : '0;
    assign w_zero_nxt  = w_fin_err || (w_fin_data == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_data  <= '0;
            r_sign  <= 1'b0;
            r_rem   <= '0;
            r_shift <= '0;
            r_rot   <= '0;
            r_zero  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op   <= in_op;
                        r_data <= in_data;
                        r_sign <= in_data[WIDTH-1];
                        r_rem  <= in_amt;
                        if (w_idle_done) begin
                            r_state <= ST_DONE;
                            r_shift <= w_shift_nxt;
                            r_rot   <= w_rot_nxt;
                            r_zero  <= w_zero_nxt;
                            r_err   <= w_fin_err;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_data <= w_step_out;
                    r_rem  <= w_rem_nxt;
                    if (w_rem_nxt == '0) begin
                        r_state <= ST_DONE;
                        r_shift <= w_shift_nxt;
                        r_rot   <= w_rot_nxt;
                        r_zero  <= w_zero_nxt;
                        r_err   <= w_fin_err;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                        r_shift <= '0;
                        r_rot   <= '0;
                        r_zero  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_shift = r_shift;
    assign out_rot   = r_rot;
    assign out_zero  = r_zero;
    assign out_err   = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_unit.sv
// Directed table plus random scoreboard bench for shift_unit (WIDTH=32, STEP=4).
module tb_shift_unit;

  localparam int N_RAND = 200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'b000;
  logic [31:0] in_data = 32'h0;
  logic [4:0]  in_amt = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_shift;
  logic [31:0] out_rot;
  logic        out_zero;
  logic        out_err;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [65:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic [4:0]  amt;
    int          hold;
    logic [31:0] e_sh;
    logic [31:0] e_rot;
    logic        e_zero;
    logic        e_err;
    int          e_lat;
  } vec_t;

  vec_t vecs[15];

  shift_unit #(.WIDTH(32), .STEP(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_shift (out_shift),
    .out_rot   (out_rot),
    .out_zero  (out_zero),
    .out_err   (out_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endfunction

  function automatic logic [65:0] model(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a);
    logic [31:0] sh;
    logic [31:0] rot;
    logic        err;
    logic        zero;
    sh  = 32'h0;
    rot = 32'h0;
    err = 1'b0;
    case (op)
      3'd0: sh = d << a;
      3'd1: sh = d >> a;
      3'd2: sh = $signed(d) >>> a;
      3'd3: rot = (a == 5'd0) ? d : ((d << a) | (d >> (6'd32 - a)));
      3'd4: rot = (a == 5'd0) ? d : ((d >> a) | (d << (6'd32 - a)));
      default: err = 1'b1;
    endcase
    if (err) zero = 1'b1;
    else if (op == 3'd3 || op == 3'd4) zero = (rot == 32'h0);
    else zero = (sh == 32'h0);
    return {err, zero, rot, sh};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_amt   = a;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int exp_lat;
    send_req(v.op, v.data, v.amt);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
`ifdef SHIFT_UNIT_FAST_EN
    exp_lat = 1;
`else
    exp_lat = v.e_lat;
`endif
    chk($sformatf("v%0d_latency", idx), 128'(lat), 128'(exp_lat));
    chk($sformatf("v%0d_shift", idx), {96'd0, out_shift}, {96'd0, v.e_sh});
    chk($sformatf("v%0d_rot", idx), {96'd0, out_rot}, {96'd0, v.e_rot});
    chk($sformatf("v%0d_zero_err", idx), {126'd0, out_zero, out_err}, {126'd0, v.e_zero, v.e_err});
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk($sformatf("v%0d_hold%0d_flags", idx, h), {126'd0, out_valid, in_ready}, {126'd0, 1'b1, 1'b0});
      chk($sformatf("v%0d_hold%0d_data", idx, h),
          {60'd0, out_err, out_zero, out_rot, out_shift}, {60'd0, v.e_err, v.e_zero, v.e_rot, v.e_sh});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("v%0d_release", idx), {126'd0, out_valid, in_ready}, {126'd0, 1'b0, 1'b1});
  endtask

  // ---------------- random scoreboard ----------------
  task automatic rand_producer();
    logic [2:0]  op;
    logic [31:0] d;
    logic [4:0]  a;
    int n;
    for (int i = 0; i < N_RAND; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      d  = $urandom();
      a  = 5'($urandom_range(0, 31));
      in_valid = 1'b1;
      in_op    = op;
      in_data  = d;
      in_amt   = a;
      n = 0;
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL rand_accept_timeout: request %0d not accepted", i);
      end
      exp_q.push_back(model(op, d, a));
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic rand_consumer();
    int          got_n;
    int          cyc;
    logic        held;
    logic [65:0] held_v;
    logic [65:0] cur;
    logic [65:0] exp;
    logic        rdy;
    got_n = 0;
    cyc   = 0;
    held  = 1'b0;
    held_v = '0;
    while (got_n < N_RAND && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      cur = {out_err, out_zero, out_rot, out_shift};
      if (held) chk("rand_hold_stable", {61'd0, out_valid, cur}, {61'd0, 1'b1, held_v});
      rdy = ($urandom_range(0, 2) != 0);
      out_ready = rdy;
      if (out_valid) begin
        if (rdy) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rand_unexpected_result: got 0x%0h with no request pending", cur);
          end else begin
            exp = exp_q.pop_front();
            chk($sformatf("rand_result%0d", got_n), {62'd0, cur}, {62'd0, exp});
          end
          got_n++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          held_v = cur;
        end
      end else begin
        held = 1'b0;
      end
    end
    chk("rand_results_received", 128'(got_n), 128'(N_RAND));
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0]  = '{3'b000, 32'h0000_0001, 5'd31, 0, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 9};
    vecs[1]  = '{3'b010, 32'h8000_0000, 5'd4,  0, 32'hF800_0000, 32'h0, 1'b0, 1'b0, 2};
    vecs[2]  = '{3'b001, 32'h8000_0000, 5'd4,  0, 32'h0800_0000, 32'h0, 1'b0, 1'b0, 2};
    vecs[3]  = '{3'b100, 32'h0000_00F1, 5'd4,  0, 32'h0, 32'h1000_000F, 1'b0, 1'b0, 2};
    vecs[4]  = '{3'b011, 32'h1234_5678, 5'd0,  0, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'b111, 32'hDEAD_BEEF, 5'd5,  5, 32'h0, 32'h0, 1'b1, 1'b1, 1};
    vecs[6]  = '{3'b011, 32'h8000_0001, 5'd31, 0, 32'h0, 32'hC000_0000, 1'b0, 1'b0, 9};
    vecs[7]  = '{3'b001, 32'h0000_000F, 5'd4,  0, 32'h0, 32'h0, 1'b1, 1'b0, 2};
    vecs[8]  = '{3'b010, 32'h7FFF_FFFF, 5'd30, 0, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 9};
    vecs[9]  = '{3'b100, 32'h0000_0001, 5'd1,  2, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 2};
    vecs[10] = '{3'b101, 32'h0000_0000, 5'd0,  0, 32'h0, 32'h0, 1'b1, 1'b1, 1};
    vecs[11] = '{3'b010, 32'h8000_0000, 5'd31, 0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 9};
    vecs[12] = '{3'b000, 32'hA5A5_A5A5, 5'd8,  0, 32'hA5A5_A500, 32'h0, 1'b0, 1'b0, 3};
    vecs[13] = '{3'b011, 32'h0000_0000, 5'd7,  0, 32'h0, 32'h0, 1'b1, 1'b0, 3};
    vecs[14] = '{3'b000, 32'hFFFF_FFFF, 5'd5,  3, 32'hFFFF_FFE0, 32'h0, 1'b0, 1'b0, 3};

    // Reset values while held in reset.
    #12;
    chk("reset_flags", {124'd0, in_ready, out_valid, out_zero, out_err}, {124'd0, 4'b1000});
    chk("reset_results", {64'd0, out_shift, out_rot}, 128'd0);
    chk("reset_state", {126'd0, dbg_state}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Reset mid-operation aborts with no output, then the unit works normally.
    send_req(3'b000, 32'h0000_0003, 5'd20);
    @(negedge clk);
`ifdef SHIFT_UNIT_FAST_EN
    chk("midrun_busy", {126'd0, in_ready, out_valid}, {126'd0, 1'b0, 1'b1});
`else
    chk("midrun_busy", {126'd0, in_ready, out_valid}, {126'd0, 1'b0, 1'b0});
`endif
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrun_reset_flags", {126'd0, in_ready, out_valid}, {126'd0, 1'b1, 1'b0});
    chk("midrun_reset_data", {64'd0, out_shift, out_rot}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_vec('{3'b000, 32'h0000_0003, 5'd20, 0, 32'h0030_0000, 32'h0, 1'b0, 1'b0, 6}, 100);

    // Back-to-back random traffic against the reference model.
    fork
      rand_producer();
      rand_consumer();
    join
    chk("rand_queue_drained", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
